// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and header field layout for the router ingress block
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: {len[5:0], addr[1:0]}
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    PARITY  = 3'd2,
    HOLD    = 3'd3,
    CHECK   = 3'd4,
    DROP    = 3'd5
  } state_t;

  // One-hot FIFO select; the invalid address selects nothing
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] a);
    logic [NUM_PORTS-1:0] r;
    r = '0;
    if (a != ADDR_INVALID) r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/router_parity.sv
// rtl/router_parity.sv - running XOR parity over header and payload, compared against the parity byte
module router_parity (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       accum,
  input  logic       check,
  input  logic [7:0] data_in,
  input  logic [7:0] check_byte,
  output logic       err
);

  logic [7:0] par;

  // Header restarts the parity and clears the sticky error; check latches the compare result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par <= '0;
      err <= 1'b0;
    end else begin
      if (load) begin
        par <= data_in;
        err <= 1'b0;
      end else if (accum) begin
        par <= par ^ data_in;
      end
      if (check) err <= (check_byte != par);
    end
  end

endmodule

// File: rtl/router_ingress.sv
// rtl/router_ingress.sv - packet ingress FSM, byte counter and output register; parity check under ROUTER_PARITY_CHECK_EN
module router_ingress
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic                 busy,
  output logic [7:0]           data_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic                 parity_done,
  output logic                 err
);

  state_t     state;
  state_t     ret_state;
  logic [1:0] addr;
  logic [5:0] cnt;
  logic       pend;
  logic       par_got;
  logic       lfd_q;

  logic [1:0] hdr_addr;
  logic [5:0] hdr_len;
  logic       dst_full;
  logic       stall;
  logic       hdr_blocked;
  logic       accept;
  logic       enter_check;

  assign hdr_addr    = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign hdr_len     = data_in[HDR_LEN_MSB:HDR_LEN_LSB];
  assign dst_full    = fifo_full[addr];
  assign stall       = pend & dst_full;
  assign hdr_blocked = (hdr_addr != ADDR_INVALID) && fifo_full[hdr_addr];
  assign accept      = pkt_valid & ~busy;

  // The registered byte is strobed only when its FIFO can take it this cycle
  assign write_enb = (pend && !dst_full) ? port_onehot(addr) : '0;
  assign lfd_state = lfd_q & (|write_enb);

  // CHECK is entered only once the parity byte has actually been written
  assign enter_check = ((state == PARITY) && par_got && !stall) ||
                       ((state == HOLD) && !dst_full && (ret_state == CHECK));

  // Busy tells the source to hold data_in: blocked header, stalled write, HOLD, CHECK
  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:        busy = pkt_valid & hdr_blocked;
      PAYLOAD:     busy = stall;
      PARITY:      busy = par_got | stall;
      HOLD, CHECK: busy = 1'b1;
      default:     busy = 1'b0;
    endcase
    if (reset) busy = 1'b0;
  end

  // Packet FSM: accept bytes, count payload, park a stalled write in HOLD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      pend        <= 1'b0;
      par_got     <= 1'b0;
      lfd_q       <= 1'b0;
      data_out    <= '0;
      parity_done <= 1'b0;
    end else begin
      parity_done <= enter_check;
      if (pend && !dst_full) begin
        pend  <= 1'b0;
        lfd_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (hdr_addr == ADDR_INVALID) begin
              state <= DROP;
            end else begin
              data_out <= data_in;
              addr     <= hdr_addr;
              cnt      <= hdr_len;
              pend     <= 1'b1;
              lfd_q    <= 1'b1;
              state    <= (hdr_len == 6'd0) ? PARITY : PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (stall) begin
            ret_state <= PAYLOAD;
            state     <= HOLD;
          end else if (accept) begin
            data_out <= data_in;
            pend     <= 1'b1;
            cnt      <= cnt - 6'd1;
            if (cnt == 6'd1) state <= PARITY;
          end
        end
        PARITY: begin
          if (stall) begin
            ret_state <= par_got ? CHECK : PARITY;
            state     <= HOLD;
          end else if (par_got) begin
            state <= CHECK;
          end else if (accept) begin
            data_out <= data_in;
            pend     <= 1'b1;
            par_got  <= 1'b1;
          end
        end
        HOLD: begin
          if (!dst_full) state <= ret_state;
        end
        CHECK: begin
          par_got <= 1'b0;
          state   <= IDLE;
        end
        DROP: begin
          if (!pkt_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic hdr_acc;
  logic pay_acc;

  assign hdr_acc = (state == IDLE) && accept && (hdr_addr != ADDR_INVALID);
  assign pay_acc = (state == PAYLOAD) && accept;

  router_parity u_parity (
    .clk        (clk),
    .reset      (reset),
    .load       (hdr_acc),
    .accum      (pay_acc),
    .check      (enter_check),
    .data_in    (data_in),
    .check_byte (data_out),
    .err        (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_ingress.sv
// tb/tb_router_ingress.sv - randomized self-checking bench for router_ingress with a packet-level model
module tb_router_ingress;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic [7:0] data_out;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic       parity_done;
  logic       err;

  router_ingress dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .data_out    (data_out),
    .write_enb   (write_enb),
    .lfd_state   (lfd_state),
    .parity_done (parity_done),
    .err         (err)
  );

  always #5 clk = ~clk;

`ifdef ROUTER_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
    bit         lfd;
    bit         last;
    bit         bad;
  } wr_t;

  wr_t  q[$];
  wr_t  e;
  int   checks = 0;
  int   errors = 0;
  bit   owed = 0, pd_exp = 0, pd_next = 0, clr_pend = 0, err_exp = 0, bad_pend = 0;
  bit   in_rst = 1, cur_live = 0, cur_hdr = 0, rand_full = 0;
  int   wcnt[3] = '{0, 0, 0};
  int   lfd_cnt = 0, pd_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] pay[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every routed byte must reach its FIFO once, in order, one cycle after acceptance unless that FIFO is full
  always @(negedge clk) begin
    if (!in_rst && reset === 1'b0) begin
      pd_next = 1'b0;
      if (clr_pend) begin
        err_exp  = 1'b0;
        clr_pend = 1'b0;
      end
      if (PCHK && pd_exp) err_exp = bad_pend;
      chk("parity_done", parity_done, pd_exp);
      chk("err", err, err_exp);
      chk("we_onehot0", $onehot0(write_enb), 1);
      if (owed && q.size() > 0) begin
        e = q[0];
        if (fifo_full[e.port]) begin
          chk("we_blocked", write_enb, 0);
          chk("busy_blocked", busy, 1);
        end else begin
          chk("we_port", write_enb, 32'd1 << e.port);
          chk("data_out", data_out, e.data);
          chk("lfd_state", lfd_state, e.lfd);
          void'(q.pop_front());
          owed = 1'b0;
          if (e.last) begin
            pd_next  = 1'b1;
            bad_pend = e.bad;
          end
        end
      end else begin
        chk("we_quiet", write_enb, 0);
        chk("lfd_quiet", lfd_state, 0);
      end
      for (int i = 0; i < 3; i++) begin
        if (write_enb[i]) begin
          wcnt[i]++;
          last_data = data_out;
        end
      end
      lfd_cnt += int'(lfd_state);
      pd_cnt  += int'(parity_done);
      if (pkt_valid && !busy && cur_live) begin
        owed = 1'b1;
        if (cur_hdr) clr_pend = 1'b1;
      end
      pd_exp = pd_next;
    end
  end

  // Random backpressure on the FIFO full flags (about one in four per port)
  always @(posedge clk) begin
    #1;
    if (rand_full) fifo_full = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
  end

  // Send header, pay[0..n-1] and (for routed packets) parity; stop_at truncates the packet
  task automatic send_pkt(input logic [7:0] hdr, input int n, input bit bad, input bit gaps, input int stop_at);
    logic [7:0] bytes[66];
    logic [7:0] par;
    bit         live;
    bit         ok;
    int         total;
    wr_t        w;
    live = (hdr[1:0] != 2'b11);
    par  = hdr;
    bytes[0] = hdr;
    for (int i = 0; i < n; i++) begin
      bytes[i+1] = pay[i];
      par = par ^ pay[i];
    end
    if (bad) par = par ^ 8'h01;
    bytes[n+1] = par;
    total = live ? n + 2 : n + 1;
    if (live) begin
      for (int i = 0; i < total; i++) begin
        w.port = hdr[1:0];
        w.data = bytes[i];
        w.lfd  = (i == 0);
        w.last = (i == total - 1);
        w.bad  = bad;
        q.push_back(w);
      end
    end
    for (int idx = 0; idx < total && idx < stop_at; idx++) begin
      if (gaps && idx > 1 && idx <= n && $urandom_range(0, 3) == 0) begin
        pkt_valid = 1'b0;
        cur_live  = 1'b0;
        @(posedge clk);
        #1;
      end
      pkt_valid = 1'b1;
      data_in   = bytes[idx];
      cur_live  = live;
      cur_hdr   = (idx == 0);
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (!busy) begin
          ok = 1'b1;
          break;
        end
      end
      chk("accept_wait", ok, 1);
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    cur_live  = 1'b0;
    cur_hdr   = 1'b0;
    data_in   = 8'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      if (q.size() == 0 && !owed) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, w2, l0, p0, hb, tot;
    bit ok;
    reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_write_enb", write_enb, 0);
    chk("rst_lfd", lfd_state, 0);
    chk("rst_parity_done", parity_done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_rst = 1'b0;

    // 8'h50: len 20 to port 0, payload 1..20, parity 8'h44
    for (int i = 0; i < 20; i++) pay[i] = 8'(i + 1);
    w0 = wcnt[0]; l0 = lfd_cnt; p0 = pd_cnt;
    send_pkt(8'h50, 20, 1'b0, 1'b0, 999);
    drain();
    chk("p50_writes", wcnt[0] - w0, 22);
    chk("p50_lfd", lfd_cnt - l0, 1);
    chk("p50_pdone", pd_cnt - p0, 1);
    chk("p50_parity", last_data, 8'h44);
    chk("p50_err", err, 0);

    // Same packet with corrupted parity, then header 8'h05 clears err
    send_pkt(8'h50, 20, 1'b1, 1'b0, 999);
    drain();
    chk("bad_parity_byte", last_data, 8'h45);
    chk("bad_err_set", err, 32'(PCHK));
    pay[0] = 8'h33;
    send_pkt(8'h05, 1, 1'b0, 1'b0, 999);
    drain();
    chk("err_cleared", err, 0);

    // 8'h0E to port 2 while fifo_full[2] is high for four cycles
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h44;
    w2 = wcnt[2]; hb = 0;
    fifo_full = 3'b100;
    fork
      send_pkt(8'h0E, 3, 1'b0, 1'b0, 999);
      begin
        repeat (4) begin
          @(negedge clk);
          if (busy) hb++;
          chk("blocked_hdr_we", write_enb, 0);
        end
        @(posedge clk);
        #1;
        fifo_full = 3'b000;
      end
    join
    drain();
    chk("blocked_busy_cycles", hb, 4);
    chk("p0E_writes", wcnt[2] - w2, 5);

    // 8'h15 to port 1: fifo_full[1] rises in the strobe cycle of payload byte 2
    for (int i = 0; i < 5; i++) pay[i] = 8'hA1 + 8'(i);
    w1 = wcnt[1]; hb = 0;
    fork
      send_pkt(8'h15, 5, 1'b0, 1'b0, 999);
      begin
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (write_enb == 3'b010 && data_out == 8'hA1) begin
            ok = 1'b1;
            break;
          end
        end
        chk("hold_trigger", ok, 1);
        @(posedge clk);
        #1;
        fifo_full = 3'b010;
        repeat (3) begin
          @(negedge clk);
          if (busy) hb++;
        end
        @(posedge clk);
        #1;
        fifo_full = 3'b000;
        @(negedge clk);
        if (busy) hb++;
      end
    join
    drain();
    chk("hold_busy_cycles", hb, 4);
    chk("p15_writes", wcnt[1] - w1, 7);

    // 8'h0F: invalid address, four bytes dropped; next packet still routed
    tot = wcnt[0] + wcnt[1] + wcnt[2];
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    send_pkt(8'h0F, 4, 1'b0, 1'b0, 999);
    drain();
    chk("drop_writes", wcnt[0] + wcnt[1] + wcnt[2] - tot, 0);
    w1 = wcnt[1];
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_pkt(8'h09, 2, 1'b0, 1'b0, 999);
    drain();
    chk("after_drop_writes", wcnt[1] - w1, 4);

    // Zero-length packet to port 2: header then parity equal to the header
    w2 = wcnt[2];
    send_pkt(8'h02, 0, 1'b0, 1'b0, 999);
    drain();
    chk("len0_writes", wcnt[2] - w2, 2);
    chk("len0_parity", last_data, 8'h02);

    // Reset after payload byte 5 of a len-10 packet, then 8'h04 completes
    for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
    send_pkt(8'h28, 10, 1'b0, 1'b0, 6);
    @(negedge clk);
    #2;
    pkt_valid = 1'b1; data_in = 8'h04; fifo_full = 3'b111;
    in_rst = 1'b1;
    reset  = 1'b1;
    #1;
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_write_enb", write_enb, 0);
    chk("mid_rst_lfd", lfd_state, 0);
    chk("mid_rst_parity_done", parity_done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    q.delete();
    owed = 1'b0; pd_exp = 1'b0; clr_pend = 1'b0; err_exp = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; pkt_valid = 1'b0; fifo_full = 3'b000;
    @(posedge clk);
    #1;
    in_rst = 1'b0;
    w0 = wcnt[0]; p0 = pd_cnt;
    pay[0] = 8'h77;
    send_pkt(8'h04, 1, 1'b0, 1'b0, 999);
    drain();
    chk("post_rst_writes", wcnt[0] - w0, 3);
    chk("post_rst_pdone", pd_cnt - p0, 1);
    chk("post_rst_parity", last_data, 8'h04 ^ 8'h77);

    // Randomized packets under random backpressure
    rand_full = 1'b1;
    for (int p = 0; p < 40; p++) begin
      logic [5:0] len;
      logic [1:0] a;
      int n;
      len = 6'($urandom_range(0, 12));
      a   = 2'($urandom_range(0, 3));
      n   = (a == 2'b11) ? int'($urandom_range(0, 5)) : int'(len);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      send_pkt({len, a}, n, 1'($urandom_range(0, 1)), (a != 2'b11) && ($urandom_range(0, 1) == 1), 999);
      drain();
    end
    rand_full = 1'b0;
    @(posedge clk);
    #1;
    fifo_full = 3'b000;
    drain();
    chk("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
